// File: rtl/pipe_scoreboard.sv
// Register-file hazard scoreboard for the issue stage.
// Tracks pending writes per (file, reg) with fixed or variable latency.
module pipe_scoreboard #(
  parameter int NREGS  = 32,
  parameter int NFILES = 2,
  parameter int LATW   = 4,
  localparam int RW = $clog2(NREGS),
  localparam int FW = (NFILES > 1) ? $clog2(NFILES) : 1,
  localparam int CW = $clog2(NFILES*NREGS+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [RW-1:0]   iss_rs1,
  input  logic [RW-1:0]   iss_rs2,
  input  logic [FW-1:0]   iss_rs1_file,
  input  logic [FW-1:0]   iss_rs2_file,
  input  logic            iss_rs1_use,
  input  logic            iss_rs2_use,
  input  logic [RW-1:0]   iss_rd,
  input  logic [FW-1:0]   iss_rd_file,
  input  logic            iss_rd_we,
  input  logic [LATW-1:0] iss_lat,
  input  logic            flush,
  input  logic            cmp_valid,
  input  logic [FW-1:0]   cmp_file,
  input  logic [RW-1:0]   cmp_rd,
  output logic            stall,
  output logic [CW-1:0]   busy_cnt,
  output logic            err
);

  logic [NFILES-1:0][NREGS-1:0]           pend;
  logic [NFILES-1:0][NREGS-1:0]           vlat;
  logic [NFILES-1:0][NREGS-1:0][LATW-1:0] cnt;

  logic p1, p2, pd, cp, cv;
  logic hazard, zero_dst, iss_set, cmp_ok;

  // Look up state for each requested index; out-of-range never matches.
  always_comb begin
    p1 = 1'b0;
    p2 = 1'b0;
    pd = 1'b0;
    cp = 1'b0;
    cv = 1'b0;
    for (int f = 0; f < NFILES; f++) begin
      for (int r = 0; r < NREGS; r++) begin
        if (FW'(f) == iss_rs1_file && RW'(r) == iss_rs1)
          p1 = pend[f][r];
        if (FW'(f) == iss_rs2_file && RW'(r) == iss_rs2)
          p2 = pend[f][r];
        if (FW'(f) == iss_rd_file && RW'(r) == iss_rd)
          pd = pend[f][r];
        if (FW'(f) == cmp_file && RW'(r) == cmp_rd) begin
          cp = pend[f][r];
          cv = vlat[f][r];
        end
      end
    end
  end

  assign hazard    = (iss_rs1_use & p1) | (iss_rs2_use & p2)
                   | (iss_rd_we & pd);
  assign iss_ready = ~hazard;
  assign stall     = iss_valid & ~iss_ready;
  assign zero_dst  = (iss_rd_file == '0) && (iss_rd == '0);
  assign iss_set   = iss_valid & iss_ready & ~flush
                   & iss_rd_we & ~zero_dst;
  assign cmp_ok    = cp & cv;

  // Popcount of pending bits.
  always_comb begin
    busy_cnt = '0;
    for (int f = 0; f < NFILES; f++)
      for (int r = 0; r < NREGS; r++)
        busy_cnt = busy_cnt + CW'(pend[f][r]);
  end

  // Countdown, completion clear, issue set and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= '0;
      vlat <= '0;
      cnt  <= '0;
      err  <= 1'b0;
    end else begin
      if (cmp_valid && !cmp_ok)
        err <= 1'b1;
      for (int f = 0; f < NFILES; f++) begin
        for (int r = 0; r < NREGS; r++) begin
          if (cnt[f][r] != '0) begin
            cnt[f][r] <= cnt[f][r] - LATW'(1);
            if (cnt[f][r] == LATW'(1))
              pend[f][r] <= 1'b0;
          end
          if (cmp_valid && cmp_ok &&
              FW'(f) == cmp_file && RW'(r) == cmp_rd) begin
            pend[f][r] <= 1'b0;
            vlat[f][r] <= 1'b0;
          end
          if (iss_set &&
              FW'(f) == iss_rd_file && RW'(r) == iss_rd) begin
            pend[f][r] <= 1'b1;
            cnt[f][r]  <= iss_lat;
            vlat[f][r] <= (iss_lat == '0);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard.
// Expected status values are queued at drive time and popped at sample time.
module tb_pipe_scoreboard;

  localparam int NREGS  = 32;
  localparam int NFILES = 2;
  localparam int LATW   = 4;
  localparam int RW     = 5;
  localparam int FW     = 1;
  localparam int CW     = 7;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            iss_valid;
  logic            iss_ready;
  logic [RW-1:0]   iss_rs1;
  logic [RW-1:0]   iss_rs2;
  logic [FW-1:0]   iss_rs1_file;
  logic [FW-1:0]   iss_rs2_file;
  logic            iss_rs1_use;
  logic            iss_rs2_use;
  logic [RW-1:0]   iss_rd;
  logic [FW-1:0]   iss_rd_file;
  logic            iss_rd_we;
  logic [LATW-1:0] iss_lat;
  logic            flush;
  logic            cmp_valid;
  logic [FW-1:0]   cmp_file;
  logic [RW-1:0]   cmp_rd;
  logic            stall;
  logic [CW-1:0]   busy_cnt;
  logic            err;

  pipe_scoreboard #(
    .NREGS(NREGS), .NFILES(NFILES), .LATW(LATW)
  ) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rs1_file(iss_rs1_file), .iss_rs2_file(iss_rs2_file),
    .iss_rs1_use(iss_rs1_use), .iss_rs2_use(iss_rs2_use),
    .iss_rd(iss_rd), .iss_rd_file(iss_rd_file),
    .iss_rd_we(iss_rd_we), .iss_lat(iss_lat),
    .flush(flush), .cmp_valid(cmp_valid),
    .cmp_file(cmp_file), .cmp_rd(cmp_rd),
    .stall(stall), .busy_cnt(busy_cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic want(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic cmp1(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty: got %0d want queued entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_bad++;
        $error("FAIL %s: got %0d want %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic expect_st(input string t, input bit st,
                           input int bc, input bit er);
    want({t, ".stall"}, 32'(st));
    want({t, ".busy"}, 32'(bc));
    want({t, ".err"}, 32'(er));
    #1;
    cmp1(32'(stall));
    cmp1(32'(busy_cnt));
    cmp1(32'(err));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic iss(input bit v, input int sf, input int s,
                     input bit u, input int df, input int d,
                     input bit we, input int lat);
    iss_valid    = v;
    iss_rs1_file = FW'(sf);
    iss_rs1      = RW'(s);
    iss_rs1_use  = u;
    iss_rd_file  = FW'(df);
    iss_rd       = RW'(d);
    iss_rd_we    = we;
    iss_lat      = LATW'(lat);
  endtask

  task automatic cmp_set(input bit v, input int f, input int r);
    cmp_valid = v;
    cmp_file  = FW'(f);
    cmp_rd    = RW'(r);
  endtask

  task automatic idle();
    iss(0, 0, 0, 0, 0, 0, 0, 0);
    iss_rs2      = '0;
    iss_rs2_file = '0;
    iss_rs2_use  = 1'b0;
    flush        = 1'b0;
    cmp_set(0, 0, 0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b0;
    #3;
    want("rst.ready", 32'd1);
    #1;
    cmp1(32'(iss_ready));
    expect_st("rst", 0, 0, 0);
    tick();
    rst = 1'b1;

    // RAW on fixed latency 3
    iss(1, 0, 0, 0, 0, 5, 1, 3);
    expect_st("t1_iss", 0, 0, 0);
    tick();
    iss(1, 0, 5, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      expect_st("t1_raw", 1, 1, 0);
      tick();
    end
    expect_st("t1_go", 0, 0, 0);
    tick();

    // latency 1: pending for exactly one cycle
    iss(1, 0, 0, 0, 0, 7, 1, 1);
    expect_st("l1_iss", 0, 0, 0);
    tick();
    idle();
    expect_st("l1_pend", 0, 1, 0);
    tick();
    expect_st("l1_done", 0, 0, 0);

    // variable-latency FP register
    iss(1, 0, 0, 0, 1, 2, 1, 0);
    expect_st("t2_iss", 0, 0, 0);
    tick();
    iss(1, 1, 2, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      expect_st("t2_hold", 1, 1, 0);
      tick();
    end
    cmp_set(1, 1, 2);
    expect_st("t2_cmp", 1, 1, 0);
    tick();
    cmp_set(0, 0, 0);
    expect_st("t2_rel", 0, 0, 0);
    tick();
    idle();

    // file separation and x0 destination
    iss(1, 0, 0, 0, 0, 3, 1, 5);
    expect_st("t3_iss", 0, 0, 0);
    tick();
    iss(1, 1, 3, 1, 0, 0, 1, 2);
    expect_st("t3_fsep", 0, 1, 0);
    tick();
    idle();
    expect_st("t3_x0", 0, 1, 0);
    tick();
    tick();
    tick();
    expect_st("t3_x3p", 0, 1, 0);
    tick();
    expect_st("t3_x3d", 0, 0, 0);

    // WAW then flush
    iss(1, 0, 0, 0, 1, 7, 1, 2);
    expect_st("t4_iss", 0, 0, 0);
    tick();
    iss(1, 0, 0, 0, 1, 7, 1, 3);
    expect_st("t4_waw1", 1, 1, 0);
    tick();
    expect_st("t4_waw2", 1, 1, 0);
    tick();
    flush = 1'b1;
    expect_st("t4_flush", 0, 0, 0);
    tick();
    idle();
    expect_st("t4_nost", 0, 0, 0);

    // flush does not stop in-flight countdown
    iss(1, 0, 0, 0, 0, 8, 1, 2);
    expect_st("t4_x8", 0, 0, 0);
    tick();
    iss(1, 0, 0, 0, 0, 9, 1, 3);
    flush = 1'b1;
    expect_st("t4_fl2", 0, 1, 0);
    tick();
    idle();
    expect_st("t4_cnt", 0, 1, 0);
    tick();
    expect_st("t4_end", 0, 0, 0);

    // protocol error, reset clears, discarded entry
    iss(1, 0, 0, 0, 1, 4, 1, 0);
    expect_st("t5_f4", 0, 0, 0);
    tick();
    idle();
    cmp_set(1, 0, 9);
    expect_st("t5_pre", 0, 1, 0);
    tick();
    cmp_set(0, 0, 0);
    expect_st("t5_err", 0, 1, 1);
    tick();
    expect_st("t5_stk", 0, 1, 1);
    rst = 1'b0;
    expect_st("t5_rst", 0, 0, 0);
    rst = 1'b1;
    tick();
    cmp_set(1, 1, 4);
    expect_st("t5_disc", 0, 0, 0);
    tick();
    cmp_set(0, 0, 0);
    expect_st("t5_derr", 0, 0, 1);
    rst = 1'b0;
    #1;
    rst = 1'b1;

    // completion aimed at a fixed-latency entry
    iss(1, 0, 0, 0, 0, 10, 1, 4);
    expect_st("t5_fx", 0, 0, 0);
    tick();
    idle();
    cmp_set(1, 0, 10);
    expect_st("t5_fxc", 0, 1, 0);
    tick();
    cmp_set(0, 0, 0);
    expect_st("t5_fxe", 0, 1, 1);
    rst = 1'b0;
    #1;
    rst = 1'b1;

    // issue X and complete Y in the same cycle
    iss(1, 0, 0, 0, 0, 11, 1, 0);
    expect_st("t7_x11", 0, 0, 0);
    tick();
    iss(1, 0, 0, 0, 0, 12, 1, 0);
    cmp_set(1, 0, 11);
    expect_st("t7_both", 0, 1, 0);
    tick();
    cmp_set(0, 0, 0);
    iss(1, 0, 11, 1, 0, 0, 0, 0);
    expect_st("t7_rd11", 0, 1, 0);
    iss(1, 0, 12, 1, 0, 0, 0, 0);
    expect_st("t7_rd12", 1, 1, 0);
    idle();
    cmp_set(1, 0, 12);
    tick();
    cmp_set(0, 0, 0);
    expect_st("t7_end", 0, 0, 0);

    // countdown clear and new issue on the same edge
    iss(1, 0, 0, 0, 0, 4, 1, 2);
    expect_st("t6_x4", 0, 0, 0);
    tick();
    idle();
    expect_st("t6_a", 0, 1, 0);
    tick();
    iss(1, 0, 0, 0, 0, 6, 1, 2);
    expect_st("t6_b", 0, 1, 0);
    tick();
    iss(1, 0, 6, 1, 0, 0, 0, 0);
    expect_st("t6_c", 1, 1, 0);
    iss(1, 0, 4, 1, 0, 0, 0, 0);
    expect_st("t6_d", 0, 1, 0);
    tick();
    idle();
    expect_st("t6_e", 0, 1, 0);
    tick();
    expect_st("t6_end", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_scoreboard.md
PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 32: registers per file.
REQ-002 SHALL have parameter NFILES, default 2: register files (0 = integer, 1 = FP).
REQ-003 SHALL have parameter LATW, default 4: latency-counter width.
REQ-004 SHALL derive RW = clog2(NREGS), FW = max(1, clog2(NFILES)), CW = clog2(NFILES*NREGS+1).
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 iss_valid  in  1  issue request from decode.
REQ-008 iss_ready  out  1  no hazard; issue may fire.
REQ-009 iss_rs1, iss_rs2  in  RW each  source register indices.
REQ-010 iss_rs1_file, iss_rs2_file  in  FW each  source file selects.
REQ-011 iss_rs1_use, iss_rs2_use  in  1 each  source operand is read.
REQ-012 iss_rd  in  RW  destination index; iss_rd_file  in  FW  destination file.
REQ-013 iss_rd_we  in  1  instruction writes a destination.
REQ-014 iss_lat  in  LATW  0 = variable latency; N>0 = result written N cycles after issue.
REQ-015 flush  in  1  blocks issue this cycle.
REQ-016 cmp_valid  in  1  variable-latency unit done; cmp_file in FW, cmp_rd in RW.
REQ-017 stall  out  1  equals iss_valid & ~iss_ready.
REQ-018 busy_cnt  out  CW  number of pending registers.
REQ-019 err  out  1  sticky protocol-error flag.

Function
REQ-020 SHALL hold, per (file, reg), a pending bit, a LATW-bit counter and a var bit.
REQ-021 Register 0 of file 0 SHALL never become pending; issue with that destination SHALL set no state.
REQ-022 hazard SHALL be (rs1_use & pending[rs1_file][rs1]) | (rs2_use & pending[rs2_file][rs2]) | (rd_we & pending[rd_file][rd]) (RAW and WAW).
REQ-023 iss_ready SHALL be ~hazard, combinational from registered state only; there is no same-cycle bypass of a completion or countdown.
REQ-024 Issue fires when iss_valid & iss_ready & ~flush; with rd_we it SHALL set pending, counter = iss_lat, and var = (iss_lat == 0).
REQ-025 Fixed entries: a counter > 0 SHALL decrement each cycle; on the 1->0 edge pending SHALL clear on that same edge.
REQ-026 iss_lat = 1 SHALL leave the register pending for exactly one cycle after issue.
REQ-027 Variable entries SHALL clear only on cmp_valid with matching cmp_file/cmp_rd.
REQ-028 A cmp_valid targeting a non-pending or fixed-latency entry SHALL change no entry and SHALL set err.
REQ-029 Issue to X and clear of Y≠X in the same cycle SHALL both take effect.
REQ-030 Issue and clear of the same register in one cycle cannot occur, because WAW blocks the issue.
REQ-031 flush SHALL affect only the issue in that cycle; in-flight entries keep counting and completing.
REQ-032 busy_cnt SHALL be the combinational popcount of all pending bits.
REQ-033 Indices with file >= NFILES or reg >= NREGS SHALL be treated as never pending and SHALL never be set.

Reset
REQ-034 On rst low, asynchronously: all pending, counters and var bits = 0; err = 0; busy_cnt = 0; iss_ready = 1.
REQ-035 On reset release, the first issue SHALL be accepted on the first rising edge with rst high.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight entries.
REQ-037 A cmp_valid arriving after reset for a discarded entry SHALL set err.

Verification
REQ-038 RAW fixed: issue rd=x5 int lat=3, then issue rs1=x5 -> stall = 1 for 3 cycles; dependent accepted in cycle 4; busy_cnt 1 -> 0.
REQ-039 Variable FP: issue rd=f2 lat=0, hold src f2 for 10 cycles -> stall = 1 throughout; cmp_valid f2 -> iss_ready = 1 next cycle, err = 0.
REQ-040 File separation: x3 pending; issue reading f3 -> accepted with no stall; write to x0 lat=2 -> busy_cnt unchanged.
REQ-041 WAW plus flush: f7 pending lat=2; issue rd=f7 stalls 2 cycles; issue under flush -> no state change, busy_cnt = 0.
REQ-042 Protocol error: cmp_valid on non-pending x9 -> err = 1 and stays 1; rst low -> err = 0, busy_cnt = 0.
REQ-043 Concurrency: x4 counter at 1 while new issue rd=x6 lat=2 -> same edge x4 clears and x6 sets; busy_cnt stays 1.
